// File: rtl/sync_fifo_ctrl.sv
// rtl/sync_fifo_ctrl.sv - pointer/occupancy controller for a single-clock FIFO built on a dp_ram
module sync_fifo_ctrl #(
  parameter int RAM_DEPTH   = 16,
  parameter int ADDR_WIDITH = 4,
  parameter int AF_LEVEL    = 12,
  parameter int AE_LEVEL    = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   write_enable,
  input  logic                   read_enable,
  output logic                   write_allow,
  output logic                   read_allow,
  output logic [ADDR_WIDITH-1:0] write_addr,
  output logic [ADDR_WIDITH-1:0] read_addr,
  output logic                   read_valid,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic [ADDR_WIDITH:0]   fifo_count,
  output logic                   overflow,
  output logic                   underflow
);

  localparam logic [ADDR_WIDITH:0] DEPTH_CNT = RAM_DEPTH[ADDR_WIDITH:0];
  localparam logic [ADDR_WIDITH:0] AF_CNT    = AF_LEVEL[ADDR_WIDITH:0];
  localparam logic [ADDR_WIDITH:0] AE_CNT    = AE_LEVEL[ADDR_WIDITH:0];
  localparam logic [ADDR_WIDITH:0] ONE_CNT   = {{ADDR_WIDITH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDITH-1:0] ONE_PTR = {{(ADDR_WIDITH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDITH-1:0] write_ptr;
  logic [ADDR_WIDITH-1:0] read_ptr;
  logic [ADDR_WIDITH:0]   count_q;
  logic [ADDR_WIDITH:0]   count_d;

  // Flags come from the registered count, so full/empty gate the strobes without a comb loop.
  assign full         = (count_q == DEPTH_CNT);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_CNT);
  assign almost_empty = (count_q <= AE_CNT);

  assign write_allow = write_enable & ~full;
  assign read_allow  = read_enable & ~empty;

  assign write_addr = write_ptr;
  assign read_addr  = read_ptr;
  assign fifo_count = count_q;

  always_comb begin
    count_d = count_q;
    case ({write_allow, read_allow})
      2'b10:   count_d = count_q + ONE_CNT;
      2'b01:   count_d = count_q - ONE_CNT;
      default: count_d = count_q;
    endcase
  end

  // Pointers wrap naturally because RAM_DEPTH is a power of two.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      write_ptr  <= '0;
      read_ptr   <= '0;
      count_q    <= '0;
      read_valid <= 1'b0;
      overflow   <= 1'b0;
      underflow  <= 1'b0;
    end else begin
      if (write_allow) write_ptr <= write_ptr + ONE_PTR;
      if (read_allow)  read_ptr  <= read_ptr + ONE_PTR;
      count_q    <= count_d;
      read_valid <= read_allow;
      overflow   <= write_enable & full;
      underflow  <= read_enable & empty;
    end
  end

endmodule
